// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg
//  Shared types and helpers for the fully-connected layer controller.
//  - ctrl_state_t : controller states (LOAD, MAC, OUT)
//  - clog2_min1   : address/counter width helper that never returns 0,
//                   so a MOD=1 counter still gets a 1-bit register.
package nn_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } ctrl_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nn_mod_counter.sv
// nn_mod_counter
//  Wrapping modulo-MOD counter used for the controller's loop indices.
//  Ports:
//   clk, reset (async, active-high)
//   i_clear  : synchronous clear to 0 (priority over i_en)
//   i_en     : advance by one, wrapping MOD-1 -> 0
//   o_cnt    : current count
//   o_wrap   : i_en && o_cnt == MOD-1 (the count wraps on this edge)
module nn_mod_counter
  import nn_ctrl_pkg::*;
#(
  parameter int MOD = 2,
  parameter int W   = clog2_min1(MOD)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = i_en && (r_cnt == LAST);

endmodule

// File: rtl/nn_ctrl_fsm.sv
// nn_ctrl_fsm
//  Sequencing controller for one fully-connected layer: M outputs, N inputs,
//  P parallel MAC lanes, G = M/P output groups. Carries no data itself.
//
//  Handshakes: a transfer happens on a rising edge where valid && ready are
//  both high. Valid, once raised, is never retracted before its transfer;
//  ready may be anything. s_* is the input-element stream, m_* the result
//  stream (results come from the datapath, selected by f_sel).
//
//  Ports:
//   clk, reset        clock; asynchronous active-high reset
//   s_valid/s_ready   input element stream (s_ready high only in LOAD)
//   m_valid/m_ready   result stream (m_valid high only in OUT)
//   m_last            final (M-th) result of the vector
//   addr_x, wr_en_x   x-memory address (write in LOAD, read in MAC), write enable
//   addr_w            weight-ROM address g*N + j
//   clear_acc, en_acc accumulator load-first-product / accumulate
//   f_sel             one-hot output lane select in OUT
//   dbg_state         current controller state
//   perf_cycles       (only with NN_CTRL_PERF_CNT_EN) cycles from first accept
//                     to the m_last transfer of the most recent vector
//
//  Configuration macro: NN_CTRL_PERF_CNT_EN adds the perf_cycles counter.
module nn_ctrl_fsm
  import nn_ctrl_pkg::*;
#(
  parameter int M = 16,
  parameter int N = 8,
  parameter int P = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              m_last,
  output logic [clog2_min1(N)-1:0]          addr_x,
  output logic                              wr_en_x,
  output logic [clog2_min1(M*N/P)-1:0]      addr_w,
  output logic                              clear_acc,
  output logic                              en_acc,
  output logic [P-1:0]                      f_sel,
`ifdef NN_CTRL_PERF_CNT_EN
  output logic [31:0]                       perf_cycles,
`endif
  output ctrl_state_t                       dbg_state
);

  localparam int G   = M / P;
  localparam int XW  = clog2_min1(N);
  localparam int JW  = clog2_min1(N + 1);
  localparam int KW  = clog2_min1(P);
  localparam int GW  = clog2_min1(G);
  localparam int AWW = clog2_min1(M * N / P);

  localparam logic [AWW-1:0] N_AW   = AWW'(N);
  localparam logic [JW-1:0]  N_J    = JW'(N);
  localparam logic [JW-1:0]  ONE_J  = JW'(1);
  localparam logic [JW-1:0]  TWO_J  = JW'(2);
  localparam logic [GW-1:0]  LAST_G = GW'(G - 1);
  localparam logic [KW-1:0]  LAST_K = KW'(P - 1);

  ctrl_state_t r_state;
  ctrl_state_t w_state_nxt;

  logic [XW-1:0] w_i;
  logic [JW-1:0] w_j;
  logic [KW-1:0] w_k;
  logic [GW-1:0] w_g;
  logic          w_i_en, w_j_en, w_k_en, w_g_en;
  logic          w_i_wrap, w_j_wrap, w_k_wrap, w_g_wrap;

  // Counter enables live outside the output decode so the wrap flags never
  // feed back into the block that produces them.
  assign w_i_en = s_valid && (r_state == LOAD);
  assign w_j_en = (r_state == MAC);
  assign w_k_en = (r_state == OUT) && m_ready;
  assign w_g_en = w_k_wrap;

  nn_mod_counter #(.MOD(N), .W(XW)) u_cnt_i (
    .clk(clk), .reset(reset), .i_clear(1'b0), .i_en(w_i_en),
    .o_cnt(w_i), .o_wrap(w_i_wrap)
  );

  nn_mod_counter #(.MOD(N + 1), .W(JW)) u_cnt_j (
    .clk(clk), .reset(reset), .i_clear(1'b0), .i_en(w_j_en),
    .o_cnt(w_j), .o_wrap(w_j_wrap)
  );

  nn_mod_counter #(.MOD(P), .W(KW)) u_cnt_k (
    .clk(clk), .reset(reset), .i_clear(1'b0), .i_en(w_k_en),
    .o_cnt(w_k), .o_wrap(w_k_wrap)
  );

  nn_mod_counter #(.MOD(G), .W(GW)) u_cnt_g (
    .clk(clk), .reset(reset), .i_clear(1'b0), .i_en(w_g_en),
    .o_cnt(w_g), .o_wrap(w_g_wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    wr_en_x     = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    addr_x      = '0;
    addr_w      = '0;
    clear_acc   = 1'b0;
    en_acc      = 1'b0;
    f_sel       = '0;

    case (r_state)
      LOAD: begin
        s_ready = 1'b1;
        wr_en_x = w_i_en;
        addr_x  = w_i;
        if (w_i_wrap) w_state_nxt = MAC;
      end
      MAC: begin
        // j==N is the drain cycle for the 1-cycle memory latency: no new
        // address, only the final accumulate.
        if (w_j < N_J) begin
          addr_x = XW'(w_j);
          addr_w = AWW'(w_g) * N_AW + AWW'(w_j);
        end
        clear_acc = (w_j == ONE_J);
        en_acc    = (w_j >= TWO_J);
        if (w_j_wrap) w_state_nxt = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        f_sel   = P'(1) << w_k;
        m_last  = (w_g == LAST_G) && (w_k == LAST_K);
        if (w_k_wrap) w_state_nxt = w_g_wrap ? LOAD : MAC;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  assign dbg_state = r_state;

`ifdef NN_CTRL_PERF_CNT_EN
  logic [31:0] r_perf_cnt;
  logic [31:0] r_perf_cycles;
  logic        r_perf_run;
  logic        w_first_acc;
  logic        w_last_hs;

  assign w_first_acc = w_i_en && (w_i == '0);
  assign w_last_hs   = w_k_wrap && w_g_wrap;

  // The count reads 1 on the cycle after the first accept, so on the m_last
  // transfer cycle it equals the number of edges since the first accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_cnt    <= '0;
      r_perf_cycles <= '0;
      r_perf_run    <= 1'b0;
    end else begin
      if (w_first_acc) begin
        r_perf_cnt <= 32'd1;
        r_perf_run <= 1'b1;
      end else if (r_perf_run && (r_perf_cnt != '1)) begin
        r_perf_cnt <= r_perf_cnt + 32'd1;
      end
      if (w_last_hs) begin
        r_perf_cycles <= r_perf_cnt;
        r_perf_run    <= 1'b0;
      end
    end
  end

  assign perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_nn_ctrl_fsm.sv
// tb_nn_ctrl_fsm
//  Two controller instances: A (M=16,N=8,P=1) and B (M=16,N=8,P=2). Only the
//  instance chosen by sel receives stimulus; the other idles in LOAD.
//  Expected behaviour is derived from the layer's loop nest: N accepts, then
//  per group N+1 MAC cycles followed by P result transfers.
module tb_nn_ctrl_fsm;
  import nn_ctrl_pkg::*;

  localparam int M = 16;
  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic sel;
  logic svd, mrd;

  logic a_s_valid, a_m_ready, b_s_valid, b_m_ready;
  assign a_s_valid = svd & ~sel;
  assign a_m_ready = mrd & ~sel;
  assign b_s_valid = svd & sel;
  assign b_m_ready = mrd & sel;

  logic        a_s_ready, a_m_valid, a_m_last, a_wr_en_x, a_clear, a_en;
  logic [2:0]  a_addr_x;
  logic [6:0]  a_addr_w;
  logic [0:0]  a_f_sel;
  ctrl_state_t a_state;
  logic        b_s_ready, b_m_valid, b_m_last, b_wr_en_x, b_clear, b_en;
  logic [2:0]  b_addr_x;
  logic [5:0]  b_addr_w;
  logic [1:0]  b_f_sel;
  ctrl_state_t b_state;
`ifdef NN_CTRL_PERF_CNT_EN
  logic [31:0] a_perf, b_perf;
`endif

  nn_ctrl_fsm #(.M(M), .N(N), .P(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .s_valid(a_s_valid), .s_ready(a_s_ready),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_last(a_m_last),
    .addr_x(a_addr_x), .wr_en_x(a_wr_en_x), .addr_w(a_addr_w),
    .clear_acc(a_clear), .en_acc(a_en), .f_sel(a_f_sel),
`ifdef NN_CTRL_PERF_CNT_EN
    .perf_cycles(a_perf),
`endif
    .dbg_state(a_state)
  );

  nn_ctrl_fsm #(.M(M), .N(N), .P(2)) u_dut_b (
    .clk(clk), .reset(reset),
    .s_valid(b_s_valid), .s_ready(b_s_ready),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_last(b_m_last),
    .addr_x(b_addr_x), .wr_en_x(b_wr_en_x), .addr_w(b_addr_w),
    .clear_acc(b_clear), .en_acc(b_en), .f_sel(b_f_sel),
`ifdef NN_CTRL_PERF_CNT_EN
    .perf_cycles(b_perf),
`endif
    .dbg_state(b_state)
  );

  // Observed signals of the selected instance.
  logic        o_s_ready, o_m_valid, o_m_last, o_wr_en_x, o_clear, o_en;
  logic [2:0]  o_addr_x;
  logic [6:0]  o_addr_w;
  logic [1:0]  o_f_sel;
  ctrl_state_t o_state;
  logic [31:0] o_perf;

  always_comb begin
    o_s_ready = sel ? b_s_ready : a_s_ready;
    o_m_valid = sel ? b_m_valid : a_m_valid;
    o_m_last  = sel ? b_m_last  : a_m_last;
    o_wr_en_x = sel ? b_wr_en_x : a_wr_en_x;
    o_clear   = sel ? b_clear   : a_clear;
    o_en      = sel ? b_en      : a_en;
    o_addr_x  = sel ? b_addr_x  : a_addr_x;
    o_addr_w  = sel ? {1'b0, b_addr_w} : a_addr_w;
    o_f_sel   = sel ? b_f_sel   : {1'b0, a_f_sel};
    o_state   = sel ? b_state   : a_state;
`ifdef NN_CTRL_PERF_CNT_EN
    o_perf    = sel ? b_perf    : a_perf;
`else
    o_perf    = '0;
`endif
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Each cycle: inputs are set just after a falling edge, outputs checked 1
  // time unit later, then tick advances to the next falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(o_s_ready), 32'd1);
    check({tag, "_m_valid"}, 32'(o_m_valid), 32'd0);
    check({tag, "_m_last"},  32'(o_m_last),  32'd0);
    check({tag, "_clear"},   32'(o_clear),   32'd0);
    check({tag, "_en"},      32'(o_en),      32'd0);
    check({tag, "_f_sel"},   32'(o_f_sel),   32'd0);
    check({tag, "_addr_x"},  32'(o_addr_x),  32'd0);
    check({tag, "_addr_w"},  32'(o_addr_w),  32'd0);
    check({tag, "_state"},   32'(o_state),   32'(LOAD));
  endtask

  // One full vector on the selected instance.
  //  gap_mode  : 0 s_valid always 1, 1 toggling 1,0,1,0.., 2 random
  //  stall_mode: 0 m_ready always 1, 1 five stall cycles on first result, 2 random
  //  abort_g   : group in which reset is pulsed at j==4 (-1: none)
  task automatic run_vector(input int p, input int gap_mode, input int stall_mode,
                            input int abort_g, input bit chk_perf);
    int   groups;
    int   t0;
    int   t1;
    int   gap_run;
    int   stalls;
    logic tog;
    logic sv;
    logic mr;
    logic last;
    groups  = M / p;
    t0      = -1;
    t1      = 0;
    gap_run = 0;
    tog     = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(32'(i));

    while (exp_q.size() > 0) begin
      case (gap_mode)
        0:       sv = 1'b1;
        1:       begin sv = tog; tog = ~tog; end
        default: sv = (gap_run >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      gap_run = sv ? 0 : gap_run + 1;
      svd = sv;
      mrd = 1'($urandom_range(0, 1));
      #1;
      check("load_s_ready", 32'(o_s_ready), 32'd1);
      check("load_wr_en_x", 32'(o_wr_en_x), 32'(sv));
      check("load_m_valid", 32'(o_m_valid), 32'd0);
      if (sv) begin
        if (t0 < 0) t0 = cyc;
        check("load_addr_x", 32'(o_addr_x), exp_q.pop_front());
      end
      tick();
    end

    for (int g = 0; g < groups; g++) begin
      for (int j = 0; j <= N; j++) begin
        if (g == abort_g && j == 4) begin
          svd   = 1'b0;
          mrd   = 1'b0;
          reset = 1'b1;
          #1;
          check_reset_outputs("rst_during");
          tick();
          check_reset_outputs("rst_held");
          reset = 1'b0;
          #1;
          check_reset_outputs("rst_after");
          @(negedge clk);
          return;
        end
        svd = 1'($urandom_range(0, 1));
        mrd = 1'($urandom_range(0, 1));
        #1;
        check("mac_s_ready", 32'(o_s_ready), 32'd0);
        check("mac_wr_en_x", 32'(o_wr_en_x), 32'd0);
        check("mac_m_valid", 32'(o_m_valid), 32'd0);
        check("mac_addr_x",  32'(o_addr_x), (j < N) ? 32'(j) : 32'd0);
        check("mac_addr_w",  32'(o_addr_w), (j < N) ? 32'(g * N + j) : 32'd0);
        check("mac_clear",   32'(o_clear), 32'(j == 1));
        check("mac_en",      32'(o_en), 32'(j >= 2));
        tick();
      end
      for (int k = 0; k < p; k++) begin
        stalls = 0;
        last   = (g == groups - 1) && (k == p - 1);
        do begin
          case (stall_mode)
            0:       mr = 1'b1;
            1:       mr = (g == 0 && k == 0 && stalls < 5) ? 1'b0 : 1'b1;
            default: mr = (stalls >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
          endcase
          mrd = mr;
          svd = 1'($urandom_range(0, 1));
          #1;
          check("out_m_valid", 32'(o_m_valid), 32'd1);
          check("out_f_sel",   32'(o_f_sel), 32'(1) << k);
          check("out_m_last",  32'(o_m_last), 32'(last));
          check("out_clear",   32'(o_clear), 32'd0);
          check("out_en",      32'(o_en), 32'd0);
          check("out_s_ready", 32'(o_s_ready), 32'd0);
          check("out_wr_en_x", 32'(o_wr_en_x), 32'd0);
          if (mr && last) t1 = cyc;
          tick();
          stalls++;
        end while (!mr);
      end
    end

    svd = 1'b0;
    mrd = 1'b0;
    #1;
    check("post_s_ready", 32'(o_s_ready), 32'd1);
    check("post_state",   32'(o_state), 32'(LOAD));
`ifdef NN_CTRL_PERF_CNT_EN
    if (chk_perf) check("perf_cycles", o_perf, 32'(t1 - t0));
`else
    if (chk_perf) t1 = t1 + 0;
`endif
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    sel   = 1'b0;
    svd   = 1'b0;
    mrd   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("por");
    check("por_perf", o_perf, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("por_released");

    run_vector(1, 0, 0, -1, 1'b1);   // straight vector, P=1
    run_vector(1, 0, 1, -1, 1'b1);   // 5-cycle stall on first result
    run_vector(1, 1, 2, -1, 1'b1);   // toggling s_valid, random m_ready
    run_vector(1, 2, 2, -1, 1'b1);   // random gaps and stalls
    run_vector(1, 0, 0, 3, 1'b0);    // reset mid-MAC, group 3, j=4
    run_vector(1, 0, 0, -1, 1'b1);   // fresh vector after the abort

    sel = 1'b1;
    @(negedge clk);
    run_vector(2, 0, 0, -1, 1'b1);   // P=2, G=8
    run_vector(2, 2, 2, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
